// File: rtl/frost32_mem_bridge.sv
// Frost32 CPU-to-memory bridge: an in-order request FIFO feeding an
// IDLE/ISSUE/RESP sequencer that steers 8/16/32-bit accesses onto byte lanes.
module frost32_mem_bridge #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [31:0]                          req_data,
  input  logic                                 req_write,
  input  logic [1:0]                           req_size,
  output logic                                 resp_valid,
  output logic [31:0]                          resp_data,
  output logic                                 resp_err,
  output logic                                 mem_req,
  input  logic                                 mem_ack,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic                                 mem_write,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic [DATA_WIDTH/8-1:0]              mem_byte_en,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [$clog2(QUEUE_DEPTH):0]         queue_count
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic                  write;
    logic [1:0]            size;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  req_t                  q_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_t                state_q, state_d;

  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_WIDTH-1:0] cur_wdata_q, cur_wdata_d;
  logic [BE_W-1:0]       cur_be_q, cur_be_d;
  logic [OFF_W-1:0]      cur_off_q, cur_off_d;
  logic [1:0]            cur_size_q, cur_size_d;
  logic                  cur_write_q, cur_write_d;
  logic                  cur_err_q, cur_err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  push, pop;
  req_t                  head;
  logic [OFF_W-1:0]      head_off;
  logic                  head_err;
  logic [BE_W-1:0]       head_size_be;
  logic [31:0]           load_lane;
  logic [31:0]           load_mask;

  assign req_ready   = (count_q != CNT_W'(QUEUE_DEPTH));
  assign push        = req_valid && req_ready;
  assign queue_count = count_q;
  assign head        = q_mem_q[rd_ptr_q];
  assign head_off    = head.addr[OFF_W-1:0];

  always_comb begin
    head_err     = 1'b0;
    head_size_be = '0;
    case (head.size)
      2'd0: begin
        head_err     = (head_off[1:0] != 2'b00);
        head_size_be = BE_W'(4'hF);
      end
      2'd1: begin
        head_err     = head_off[0];
        head_size_be = BE_W'(4'h3);
      end
      2'd2: head_size_be = BE_W'(4'h1);
      default: head_err = 1'b1;
    endcase
  end

  always_comb begin
    load_lane = 32'(mem_rdata >> {cur_off_q, 3'b000});
    case (cur_size_q)
      2'd0:    load_mask = 32'hFFFF_FFFF;
      2'd1:    load_mask = 32'h0000_FFFF;
      2'd2:    load_mask = 32'h0000_00FF;
      default: load_mask = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    cur_be_d    = cur_be_q;
    cur_off_d   = cur_off_q;
    cur_size_d  = cur_size_q;
    cur_write_d = cur_write_q;
    cur_err_d   = cur_err_q;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_byte_en = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          cur_addr_d  = {head.addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          cur_wdata_d = DATA_WIDTH'(head.data) << {head_off, 3'b000};
          cur_be_d    = head_size_be << head_off;
          cur_off_d   = head_off;
          cur_size_d  = head.size;
          cur_write_d = head.write;
          cur_err_d   = head_err;
          rdata_d     = '0;
          state_d     = head_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req     = 1'b1;
        mem_write   = cur_write_q;
        mem_byte_en = cur_be_q;
        mem_addr    = cur_addr_q;
        mem_wdata   = cur_wdata_q;
        if (mem_ack) begin
          rdata_d = cur_write_q ? 32'h0 : (load_lane & load_mask);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = cur_err_q;
        resp_data  = rdata_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage carries no reset: entries are only read when count_q says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem_q[wr_ptr_q] <= '{addr: req_addr, data: req_data, write: req_write, size: req_size};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      cur_be_q    <= '0;
      cur_off_q   <= '0;
      cur_size_q  <= '0;
      cur_write_q <= 1'b0;
      cur_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      cur_be_q    <= cur_be_d;
      cur_off_q   <= cur_off_d;
      cur_size_q  <= cur_size_d;
      cur_write_q <= cur_write_d;
      cur_err_q   <= cur_err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: doc/frost32_mem_bridge.md
# frost32_mem_bridge

Parametrised memory-access bridge between the Frost32 CPU core and a word-organised memory port. It accepts CPU load and store requests (address, data, read/write, access size) into an in-order request queue. It steers 8/16/32-bit accesses onto byte lanes of a `DATA_WIDTH`-wide memory bus and flags misaligned or bad-size accesses without touching memory. It returns one response per request, in request order.

## Interface
Parameters:
- `DATA_WIDTH`, 32: memory bus width in bits; power of two, at least 32.
- `ADDR_WIDTH`, 32: byte-address width.
- `QUEUE_DEPTH`, 4: request queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_addr`  in  `ADDR_WIDTH`  byte address.
- `req_data`  in  32  store data, right-justified.
- `req_write`  in  1  0 = read (Diat read), 1 = write.
- `req_size`  in  2  0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = bad.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_data`  out  32  load data, zero-extended; 0 for stores and errors.
- `resp_err`  out  1  misaligned or bad-size request; valid with `resp_valid`.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_addr`  out  `ADDR_WIDTH`  word-aligned address (low `log2(DATA_WIDTH/8)` bits = 0).
- `mem_write`  out  1  write strobe qualifier.
- `mem_wdata`  out  `DATA_WIDTH`  store data replicated/shifted to the lane.
- `mem_byte_en`  out  `DATA_WIDTH/8`  active byte lanes.
- `mem_rdata`  in  `DATA_WIDTH`  read data; sampled when `mem_ack` = 1.
- `queue_count`  out  `log2(QUEUE_DEPTH)+1`  occupied entries.

## Operation
- Queue: circular FIFO with read and write pointers plus a count. Push occurs on `req_valid && req_ready`; pop occurs in state IDLE when the queue is non-empty.
- Simultaneous push and pop leaves the count unchanged. When the queue is full, `req_ready` = 0 even if a pop happens that cycle.
- Byte offset `off = addr[log2(DATA_WIDTH/8)-1:0]`.
- Alignment rules:
  - size 0 needs `off[1:0]` = 0.
  - size 1 needs `off[0]` = 0.
  - size 2 is always aligned.
  - size 3 is always an error.
- Byte enables: the size mask (0xF, 0x3, 0x1) is shifted left by `off`.
- `mem_wdata` = `req_data` shifted left by `8*off`, zero-filled.
- Load data = `mem_rdata >> 8*off`, masked to the access size, zero-extended to 32 bits.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into the current-op register. An error op goes to RESP; any other op goes to ISSUE.
  - ISSUE: `mem_req` = 1 and the memory outputs are driven from the current-op register. On `mem_ack`, capture the extracted load data and go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then IDLE.
- In every state other than ISSUE, `mem_req`, `mem_write` and `mem_byte_en` are 0.
- Error ops never assert `mem_req`.
- Responses are strictly in acceptance order.
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0, `mem_req` = 0, `mem_write` = 0, `mem_byte_en` = 0, `mem_addr` = 0, `mem_wdata` = 0, `queue_count` = 0, FSM = IDLE.
- Reset mid-operation:
  - The queue is flushed and any in-flight request is abandoned; `mem_req` is 0 in the first cycle after reset is sampled.
  - A `mem_ack` arriving during or after reset for the abandoned request is ignored.

## Timing
- Request accepted in cycle N. The FSM pops it in cycle N+1 and is in ISSUE with `mem_req` = 1 in cycle N+2.
- With `mem_ack` in cycle N+2, `resp_valid` is asserted in cycle N+3. Minimum load/store latency is 3 cycles.
- Each wait cycle (`mem_ack` = 0) adds one cycle of latency.
- Error path: `resp_valid` with `resp_err` = 1 in cycle N+2; no memory cycle.
- Back-to-back throughput: one response per 3 cycles with zero wait states (IDLE, ISSUE, RESP).
- `queue_count` updates the cycle after each push or pop.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF, size 0, `DATA_WIDTH` = 32 -> in cycle N+2 `mem_addr` = 0x100, `mem_byte_en` = 0xF, `mem_wdata` = 0xDEADBEEF; `resp_valid` in N+3 with `resp_err` = 0.
- Byte load: addr 0x103, size 2, `mem_rdata` = 0x8877_6655 -> `mem_byte_en` = 0x8, `resp_data` = 0x00000088. Repeat with `DATA_WIDTH` = 64 and addr 0x106, giving `mem_byte_en` = 0x40.
- Misalignment: 32-bit access at 0x102, 16-bit at 0x101, and size 3 -> each gives `resp_err` = 1 at N+2 with `mem_req` never asserted.
- Queue full: issue 5 requests back-to-back with `QUEUE_DEPTH` = 4 and `mem_ack` held low -> `req_ready` deasserts once 4 entries are held; releasing `mem_ack` returns all 5 responses in order.
- Wait states: `mem_ack` delayed 3 cycles -> `mem_req` and its outputs are stable for 4 cycles, and `resp_valid` arrives at N+6.
- Reset mid-ISSUE: assert `rst` while `mem_req` = 1 -> `mem_req` = 0 and `queue_count` = 0 in the next cycle; a later `mem_ack` produces no `resp_valid`.
